// File: rtl/mem_bridge_pkg.sv
// ============================================================================
// mem_bridge_pkg : shared widths, default address bases and FSM encoding
// Revision       : 1.0
// ============================================================================
`default_nettype none

package mem_bridge_pkg;

    localparam int EXT_AW = 18;
    localparam int DW     = 16;

    localparam logic [EXT_AW-1:0] DEF_INSTR_BASE = 18'h00000;
    localparam logic [EXT_AW-1:0] DEF_DATA_BASE  = 18'h20000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_DATA_RD  = 3'd3,
        ST_DATA_WR  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_instr_buf.sv
// ============================================================================
// mem_instr_buf : one-entry tagged instruction buffer with low-half latch
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_instr_buf
    import mem_bridge_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   prog_addr,
    input  logic            lo_ack,
    input  logic            hi_ack,
    input  logic [DW-1:0]   ext_rdata,
    output logic [2*DW-1:0] instr,
    output logic            instr_valid
);

    logic [DW-1:0]   r_pend_tag;
    logic [DW-1:0]   r_tag;
    logic [DW-1:0]   r_lo;
    logic [2*DW-1:0] r_hold;
    logic            r_hvalid;

    // The tag is the address latched at fetch start, so a PC change
    // mid-fetch leaves a stale (mismatching) entry rather than a wrong one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_tag <= '0;
            r_tag      <= '0;
            r_lo       <= '0;
            r_hold     <= '0;
            r_hvalid   <= 1'b0;
        end else begin
            if (start) begin
                r_pend_tag <= prog_addr;
            end
            if (lo_ack) begin
                r_lo <= ext_rdata;
            end
            if (hi_ack) begin
                r_hold   <= {ext_rdata, r_lo};
                r_tag    <= r_pend_tag;
                r_hvalid <= 1'b1;
            end
        end
    end

    assign instr       = r_hold;
    assign instr_valid = r_hvalid && (r_tag == prog_addr);

endmodule

`default_nettype wire

// File: rtl/mem_bridge.sv
// ============================================================================
// mem_bridge : arbitrates instruction fetch and data load/store onto one
//              16-bit external memory port
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter logic [EXT_AW-1:0] INSTR_BASE = DEF_INSTR_BASE,
    parameter logic [EXT_AW-1:0] DATA_BASE  = DEF_DATA_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     prog_addr,
    input  logic [DW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    input  logic              rd,
    input  logic              wr,
    output logic [2*DW-1:0]   instr,
    output logic              instr_valid,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              ready,
    output logic [EXT_AW-1:0] ext_addr,
    output logic [DW-1:0]     ext_wdata,
    output logic              ext_we,
    output logic              ext_req,
    input  logic [DW-1:0]     ext_rdata,
    input  logic              ext_ack
);

    state_t r_state;
    state_t w_next;
    logic   r_done;
    logic   w_accept;
    logic   w_fetch_start;
    logic   w_data_start;
    logic   w_lo_ack;
    logic   w_hi_ack;
    logic   w_data_ack;

    // r_done blocks a request the core is still holding after its ready pulse
    assign w_accept = (rd || wr) && !r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = wr ? ST_DATA_WR : ST_DATA_RD;
                end else if (!instr_valid) begin
                    w_next = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: if (ext_ack) w_next = ST_FETCH_HI;
            ST_FETCH_HI: if (ext_ack) w_next = ST_IDLE;
            ST_DATA_RD,
            ST_DATA_WR:  if (ext_ack) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        w_fetch_start = 1'b0;
        w_data_start  = 1'b0;
        w_lo_ack      = 1'b0;
        w_hi_ack      = 1'b0;
        w_data_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_data_start  = w_accept;
                w_fetch_start = !w_accept && !instr_valid;
            end
            ST_FETCH_LO: w_lo_ack = ext_ack;
            ST_FETCH_HI: w_hi_ack = ext_ack;
            ST_DATA_RD,
            ST_DATA_WR: begin
                busy       = 1'b1;
                w_data_ack = ext_ack;
            end
            default: ;
        endcase
    end

    // ext_req is high throughout every non-IDLE state, so ext_ack is only
    // ever looked at while a request is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            ready <= w_data_ack;
            if (w_data_ack) begin
                r_done <= 1'b1;
            end else if (!(rd || wr)) begin
                r_done <= 1'b0;
            end
            if (w_data_ack && (r_state == ST_DATA_RD)) begin
                rdata <= ext_rdata;
            end
            if (w_fetch_start) begin
                ext_req  <= 1'b1;
                ext_we   <= 1'b0;
                ext_addr <= INSTR_BASE + {1'b0, prog_addr, 1'b0};
            end else if (w_data_start) begin
                ext_req   <= 1'b1;
                ext_we    <= wr;
                ext_addr  <= DATA_BASE + {2'b00, addr};
                ext_wdata <= wdata;
            end else if (w_lo_ack) begin
                ext_addr <= ext_addr + 18'd1;
            end else if (w_hi_ack || w_data_ack) begin
                ext_req <= 1'b0;
                ext_we  <= 1'b0;
            end
        end
    end

    mem_instr_buf u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .start       (w_fetch_start),
        .prog_addr   (prog_addr),
        .lo_ack      (w_lo_ack),
        .hi_ack      (w_hi_ack),
        .ext_rdata   (ext_rdata),
        .instr       (instr),
        .instr_valid (instr_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
// ============================================================================
// tb_mem_bridge : directed table-driven bench for mem_bridge
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bridge;

    logic        clk;
    logic        rst;
    logic [15:0] prog_addr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] rdata;
    logic        busy;
    logic        ready;
    logic [17:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic [15:0] ext_rdata;
    logic        ext_ack;

    mem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .prog_addr   (prog_addr),
        .addr        (addr),
        .wdata       (wdata),
        .rd          (rd),
        .wr          (wr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .rdata       (rdata),
        .busy        (busy),
        .ready       (ready),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_we      (ext_we),
        .ext_req     (ext_req),
        .ext_rdata   (ext_rdata),
        .ext_ack     (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external memory model ----------------
    logic [15:0] mem [0:262143];
    int          waits;
    int          wcnt;
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    typedef struct {
        logic [17:0] a;
        logic        we;
        logic [15:0] d;
    } txn_t;
    txn_t log_q[$];

    assign ext_ack   = ext_req && (wcnt >= waits);
    assign ext_rdata = mem[ext_addr];

    always @(posedge clk) begin
        if (!ext_req || ext_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ext_req && ext_ack && ext_we) mem[ext_addr] <= ext_wdata;
        if (ext_req && ext_ack) log_q.push_back('{ext_addr, ext_we, ext_wdata});
    end

    // ---------------- checking helpers ----------------
    int n_vec;
    int n_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] la(input int i);
        if (i < log_q.size()) return log_q[i].a;
        return 'x;
    endfunction

    function automatic logic lwe(input int i);
        if (i < log_q.size()) return log_q[i].we;
        return 1'bx;
    endfunction

    function automatic logic [15:0] lwd(input int i);
        if (i < log_q.size()) return log_q[i].d;
        return 'x;
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!instr_valid && lat < max);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [15:0] pa;
        logic [15:0] lo;
        logic [15:0] hi;
        int          w;
        logic [17:0] a_lo;
        logic [17:0] a_hi;
        logic [31:0] exp_instr;
        int          exp_lat;
    } fvec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] pre;
        int          w;
        logic [17:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_rdata;
        int          exp_busy;
    } dvec_t;

    fvec_t ft[4];
    dvec_t dt[4];

    task automatic run_data(input dvec_t v);
        int bc;
        int extra;
        logic got;
        preload(v.exp_addr, v.pre);
        waits = v.w;
        log_q.delete();
        addr  = v.addr;
        wdata = v.wdata;
        rd    = v.rd;
        wr    = v.wr;
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy)  bc++;
            if (ready) got = 1'b1;
        end
        chk("data_ready_seen", 64'(got), 64'd1);
        chk("data_busy_cycles", 64'(bc), 64'(v.exp_busy));
        chk("data_rdata", 64'(rdata), 64'(v.exp_rdata));
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready) extra++;
        end
        chk("data_no_reissue", 64'(log_q.size()), 64'd1);
        chk("data_single_ready", 64'(extra), 64'd0);
        chk("data_ext_addr", 64'(la(0)), 64'(v.exp_addr));
        chk("data_ext_we", 64'(lwe(0)), 64'(v.exp_we));
        if (v.exp_we) begin
            chk("data_ext_wdata", 64'(lwd(0)), 64'(v.wdata));
            chk("data_mem_written", 64'(mem[v.exp_addr]), 64'(v.wdata));
        end
        chk("data_buf_still_valid", 64'(instr_valid), 64'd1);
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        logic got;
        logic stale;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        prog_addr = '0;
        waits = 0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;

        ft[0] = '{16'h0007, 16'h1111, 16'h2222, 0, 18'h0000E, 18'h0000F, 32'h22221111, 3};
        ft[1] = '{16'hFFFF, 16'h5A5A, 16'hA5A5, 0, 18'h1FFFE, 18'h1FFFF, 32'hA5A55A5A, 3};
        ft[2] = '{16'h1234, 16'hCAFE, 16'hF00D, 1, 18'h02468, 18'h02469, 32'hF00DCAFE, 5};
        ft[3] = '{16'h8000, 16'h0001, 16'h8000, 2, 18'h10000, 18'h10001, 32'h80000001, 7};

        dt[0] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h00FF, 2, 18'h20005, 1'b0, 16'h00FF, 3};
        dt[1] = '{1'b0, 1'b1, 16'h0010, 16'h1357, 16'h0000, 0, 18'h20010, 1'b1, 16'h00FF, 1};
        dt[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h2468, 16'h0000, 1, 18'h2FFFF, 1'b1, 16'h00FF, 2};
        dt[3] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 16'h7E57, 0, 18'h21000, 1'b0, 16'h7E57, 1};

        // reset state, with fetch words preloaded while reset is held
        preload(18'h00000, 16'h1234);
        preload(18'h00001, 16'hABCD);
        for (int i = 0; i < 4; i++) begin
            preload(ft[i].a_lo, ft[i].lo);
            preload(ft[i].a_hi, ft[i].hi);
        end
        chk("rst_ext_req", 64'(ext_req), 64'd0);
        chk("rst_ext_we", 64'(ext_we), 64'd0);
        chk("rst_ext_addr", 64'(ext_addr), 64'd0);
        chk("rst_ext_wdata", 64'(ext_wdata), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);

        // first fetch after reset release
        log_q.delete();
        rst = 1'b0;
        wait_valid(20, lat);
        chk("rstfetch_latency", 64'(lat), 64'd3);
        chk("rstfetch_instr", 64'(instr), 64'hABCD1234);
        chk("rstfetch_addr_lo", 64'(la(0)), 64'h00000);
        chk("rstfetch_addr_hi", 64'(la(1)), 64'h00001);

        // fetch table
        for (int i = 0; i < 4; i++) begin
            waits = ft[i].w;
            log_q.delete();
            prog_addr = ft[i].pa;
            wait_valid(30, lat);
            chk("fetch_latency", 64'(lat), 64'(ft[i].exp_lat));
            chk("fetch_valid", 64'(instr_valid), 64'd1);
            chk("fetch_instr", 64'(instr), 64'(ft[i].exp_instr));
            chk("fetch_addr_lo", 64'(la(0)), 64'(ft[i].a_lo));
            chk("fetch_addr_hi", 64'(la(1)), 64'(ft[i].a_hi));
            chk("fetch_not_write", 64'(lwe(0)), 64'd0);
        end

        // data table
        for (int i = 0; i < 4; i++) begin
            run_data(dt[i]);
        end

        // PC change while FETCH_HI is outstanding
        waits = 1;
        log_q.delete();
        prog_addr = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ext_req && ext_addr == 18'h00001) break;
        end
        chk("pcchg_in_fetch_hi", 64'(ext_req && ext_addr == 18'h00001), 64'd1);
        prog_addr = 16'h0007;
        stale = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!instr_valid && instr == 32'hABCD1234) stale = 1'b1;
        end while (!instr_valid && lat < 40);
        chk("pcchg_valid", 64'(instr_valid), 64'd1);
        chk("pcchg_stale_seen", 64'(stale), 64'd1);
        chk("pcchg_txn_count", 64'(log_q.size()), 64'd4);
        chk("pcchg_addr0", 64'(la(0)), 64'h00000);
        chk("pcchg_addr1", 64'(la(1)), 64'h00001);
        chk("pcchg_addr2", 64'(la(2)), 64'h0000E);
        chk("pcchg_addr3", 64'(la(3)), 64'h0000F);
        chk("pcchg_instr", 64'(instr), 64'h22221111);

        // store raised during FETCH_LO waits for the fetch to finish
        waits = 0;
        log_q.delete();
        prog_addr = 16'h1234;
        @(negedge clk);
        chk("dfetch_in_lo", 64'(ext_req && ext_addr == 18'h02468), 64'd1);
        addr  = 16'h0042;
        wdata = 16'hBEEF;
        wr    = 1'b1;
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy)  bc++;
            if (ready) got = 1'b1;
        end
        chk("dfetch_ready", 64'(got), 64'd1);
        chk("dfetch_busy_cycles", 64'(bc), 64'd1);
        chk("dfetch_txn_count", 64'(log_q.size()), 64'd3);
        chk("dfetch_addr0", 64'(la(0)), 64'h02468);
        chk("dfetch_addr1", 64'(la(1)), 64'h02469);
        chk("dfetch_addr2", 64'(la(2)), 64'h20042);
        chk("dfetch_we2", 64'(lwe(2)), 64'd1);
        chk("dfetch_wdata2", 64'(lwd(2)), 64'hBEEF);
        wr = 1'b0;
        @(negedge clk);
        chk("dfetch_buf_valid", 64'(instr_valid), 64'd1);
        chk("dfetch_instr", 64'(instr), 64'hF00DCAFE);
        chk("dfetch_mem", 64'(mem[18'h20042]), 64'hBEEF);

        // asynchronous reset while a load is outstanding
        waits = 3;
        log_q.delete();
        addr = 16'h0003;
        rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("rstmid_busy_before", 64'(busy && ext_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ext_req", 64'(ext_req), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_ready", 64'(ready), 64'd0);
        chk("rstmid_instr_valid", 64'(instr_valid), 64'd0);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        waits = 0;
        log_q.delete();
        prog_addr = 16'h0007;
        rst = 1'b0;
        wait_valid(20, lat);
        chk("rstmid_refetch_latency", 64'(lat), 64'd3);
        chk("rstmid_refetch_addr", 64'(la(0)), 64'h0000E);
        chk("rstmid_refetch_instr", 64'(instr), 64'h22221111);
        chk("rstmid_no_load", 64'(log_q.size()), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bridge.md
# mem_bridge

Memory bridge between the `cpu` core and a single-port 16-bit external memory. It serves two clients over one port:
- instruction fetch: two 16-bit reads per 32-bit instruction, held in a one-entry tagged buffer;
- data load/store: one 16-bit access.

The bridge drives the core's `e_instr`, `e_mem_bus`, `e_mem_busy` and `e_mem_ready` inputs. It consumes `e_prog_addr`, `e_addr_bus`, `e_data`, `ram_read` and `ram_write`.

## Interface
- INSTR_BASE, 18'h00000, external base address of instruction space
- DATA_BASE, 18'h20000, external base address of data space
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- prog_addr  in  16  instruction address from the core (instruction = 2 words)
- addr  in  16  data word address
- wdata  in  16  store data
- rd  in  1  load request, held by the core until `ready`
- wr  in  1  store request, held by the core until `ready`
- instr  out  32  buffered instruction; [15:0] is the low word, [31:16] the high word
- instr_valid  out  1  `instr` matches the current `prog_addr`; the core stalls while low
- rdata  out  16  load data; holds its value until the next load completes
- busy  out  1  data access in progress
- ready  out  1  one-cycle completion pulse for a data access
- ext_addr  out  18  external word address
- ext_wdata  out  16  external write data
- ext_we  out  1  external write enable
- ext_req  out  1  external request
- ext_rdata  in  16  external read data, valid when `ext_ack` is high
- ext_ack  in  1  external acknowledge; may be high in the same cycle `ext_req` rises

## Operation
- **FSM states:** IDLE, FETCH_LO, FETCH_HI, DATA_RD, DATA_WR.
- **Instruction buffer:** `tag[15:0]`, `hold[31:0]`, `hvalid`.
  - `instr_valid = hvalid && tag == prog_addr`. This output is combinational.
- **Data request acceptance:** in IDLE, a data request is accepted when `(rd|wr)` is high and `done` is clear.
  - `done` is set on the `ready` cycle and cleared when `rd|wr` is low.
  - This prevents a held request from being re-issued.
  - `rd` and `wr` both high → treated as a write.
- **Priority in IDLE:** an accepted data request beats a fetch. Otherwise a fetch starts when `instr_valid` is low.
- **Fetch sequence:**
  - FETCH_LO address: `INSTR_BASE + {1'b0, prog_addr, 1'b0}`.
  - FETCH_HI address: the FETCH_LO address + 1.
  - The fetch address is latched at fetch start.
  - On the FETCH_HI ack: `hold` ← {ext_rdata, lo}, `tag` ← latched address, `hvalid` ← 1.
- **PC change mid-fetch:** the in-flight external transaction completes; it is never aborted. The buffer is then loaded with the latched tag. `instr_valid` stays low because the tag mismatches, and a new fetch starts from IDLE.
- **Data access:** `ext_addr = DATA_BASE + {2'b0, addr}`, `ext_we = 1` for stores, `ext_wdata = wdata`. On ack the FSM returns to IDLE; for loads, `rdata` ← `ext_rdata`.
- **Coherency:** instruction and data spaces are disjoint. Stores never invalidate the buffer.
- **Address arithmetic:** 18-bit, modulo 2^18. `prog_addr` = 16'hFFFF fetches external words 1FFFE/1FFFF with INSTR_BASE = 0.

## Timing
- **External handshake:**
  - `ext_req`, `ext_addr`, `ext_we` and `ext_wdata` are registered outputs.
  - They stay stable from the cycle `ext_req` rises until the cycle `ext_ack` is sampled high.
  - The next transaction may present a new address with `ext_req` still high in the following cycle; no gap is required.
  - `ext_ack` while `ext_req` is low is ignored.
- **Fetch latency, zero-wait memory:** miss seen in cycle N → FETCH_LO request in N+1 → FETCH_HI request in N+2 → `instr_valid` high in N+3.
- **Data latency, zero-wait memory:** request accepted in N → `busy` high in N+1 (`ext_req` in N+1, ack in N+1) → `ready` high and `busy` low in N+2. For loads, `rdata` is valid in N+2.
- **`busy`:** high from the cycle after acceptance up to the cycle before `ready`.
- **Wait states:** each extra wait cycle adds one cycle to the latency.
- **Request during a fetch:** a data request that arrives during a fetch waits until the fetch completes. `busy` stays low until the request is accepted.
- **Reset values:** state IDLE, `ext_req` 0, `ext_we` 0, `ext_addr` 0, `ext_wdata` 0, `instr` 0, `instr_valid` 0, `hvalid` 0, `rdata` 0, `busy` 0, `ready` 0, `done` 0.
  - Reset takes effect immediately; a transaction in flight is dropped.
  - After release, the first fetch starts one cycle later.

## Structure
- Package `mem_bridge_pkg`: FSM state enum; default INSTR_BASE/DATA_BASE constants; width constants (EXT_AW = 18, DW = 16).
- One sub-module: `mem_instr_buf`, holding the tag, the 32-bit hold register, `hvalid`, the low-half latch and the compare logic.
- The FSM and external port registers stay in the top level.

## Test plan
- **Reset fetch:** reset released, zero-wait memory with words 0/1 = 16'h1234/16'hABCD, `prog_addr` = 0 → `instr` = 32'hABCD1234 and `instr_valid` high 3 cycles after the first miss cycle.
- **Load:** `rd` = 1, `addr` = 16'h0005, memory[20005] = 16'h00FF, 2 wait states → `busy` high for 3 cycles, `ready` one pulse, `rdata` = 16'h00FF. Holding `rd` through `ready` causes no second request.
- **PC change mid-fetch:** `prog_addr` changes 0→7 during FETCH_HI → the current ack completes, `instr_valid` stays low, ext addresses 0000E/0000F are issued next, and `instr_valid` rises with the new word.
- **Data during fetch:** `wr` = 1 raised during FETCH_LO with `wdata` = 16'hBEEF → the fetch finishes first, then a single `ext_we` access at 20000+`addr`, then `ready`. The buffer remains valid.
- **Reset mid-access:** `rst` asserted while `ext_req` is high in DATA_RD → `ext_req`, `busy`, `ready` and `instr_valid` are 0 in the same cycle; after release, the fetch restarts from `prog_addr`.
- **Wrap-around and simultaneous requests:** `prog_addr` = 16'hFFFF → ext addresses 1FFFE/1FFFF. `rd` and `wr` both high → a write is performed.
